// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

  localparam int               XLEN        = 32;
  localparam logic [XLEN-1:0]  BUBBLE_INST = 32'h0000_0000;
  localparam logic [XLEN-1:0]  PC_STEP     = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// In-order prefetch queue of {pc, inst} entries; flush beats push and pop.
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  if_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output if_entry_t     head,
  output logic [CW-1:0] count
);

  localparam int            PW     = $clog2(DEPTH);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  if_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + P_ONE;
      if (pop)  rd_d = rd_q + P_ONE;
      if (push && !pop)      count_d = count_q + C_ONE;
      else if (!push && pop) count_d = count_q - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= push_data;
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: credit-limited requests to imem, in-order prefetch queue,
// redirect flush with discard of in-flight responses, one instruction per cycle to decode.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic            grant, rsp_ok, push, pop;
  logic [XLEN-1:0] target_pc;
  if_entry_t       head, push_data;
  logic            unused_rpc_lo;

  // Handshake: a request transfers on a cycle with imem_req && imem_gnt; each
  // transfer earns exactly one in-order imem_rvalid at least one cycle later.
  // Queue entries plus outstanding requests never exceed DEPTH, so no overflow.
  assign imem_req  = !rst && !redirect &&
                     (({1'b0, count} + {1'b0, outst_q}) < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign rsp_ok    = imem_rvalid && (outst_q != '0);
  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_rpc_lo = ^redirect_pc[1:0];
  assign push_data = '{pc: resp_pc_q, inst: imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    last_pc_d  = last_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    push       = 1'b0;
    pop        = 1'b0;
    case ({grant, rsp_ok})
      2'b10:   outst_d = outst_q + C_ONE;
      2'b01:   outst_d = outst_q - C_ONE;
      default: outst_d = outst_q;
    endcase
    if (inst_valid) last_pc_d = head.pc;
    if (redirect) begin
      // Everything already requested belongs to the old path and must be discarded.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = rsp_ok ? (outst_q - C_ONE) : outst_q;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - C_ONE;
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + PC_STEP;
        end
      end
      pop = inst_valid && !id_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      last_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      last_pc_q  <= last_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  if_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head.inst : BUBBLE_INST;
  assign inst_pc    = inst_valid ? head.pc : last_pc_q;

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit: the producer end of the decode stage's instruction interface. It issues word-aligned requests to instruction memory, buffers returned words in a small in-order prefetch queue, and presents one instruction per cycle to decode together with its PC. It accepts redirects (branch/jump target from EX) and stalls (hazard unit) from downstream. When the queue is empty it drives an all-zero instruction, which decode treats as a bubble (opcode 0 = no instruction).

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: prefetch queue entries; a power of 2, at least 2; also caps outstanding requests.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `imem_req`  out  1: request valid.
- `imem_addr`  out  32: request address, bits [1:0] always 0.
- `imem_gnt`  in  1: memory accepts the request this cycle (`imem_req && imem_gnt`).
- `imem_rvalid`  in  1: response word valid. Responses return in order, at least 1 cycle after grant.
- `imem_rdata`  in  32: response instruction word.
- `redirect`  in  1: flush and refetch from `redirect_pc`.
- `redirect_pc`  in  32: new fetch PC; bits [1:0] are ignored (treated as 0).
- `id_stall`  in  1: decode holds its current instruction.
- `inst`  out  32: instruction to decode; 32'h0 when `inst_valid`=0.
- `inst_pc`  out  32: PC of `inst`; holds its last value when invalid.
- `inst_valid`  out  1: queue head is valid.

## Operation
- State:
  - `fetch_pc`: next request address.
  - `resp_pc`: PC of the next kept response.
  - `outstanding` (0..DEPTH): granted requests with no response yet.
  - `drop_cnt` (0..DEPTH): responses still to discard.
  - FIFO of {pc, inst} holding `count` entries.
- Request issue:
  - `imem_req` = !rst && !redirect && (count + outstanding < DEPTH).
  - `imem_addr` = `fetch_pc`.
  - On grant, `fetch_pc` += 4 (wraps modulo 2^32) and `outstanding` += 1.
- Response handling:
  - Each `imem_rvalid` decrements `outstanding`.
  - If `drop_cnt` > 0, the word is discarded and `drop_cnt` decrements.
  - Otherwise {`resp_pc`, `imem_rdata`} is pushed and `resp_pc` += 4.
  - The credit rule makes overflow impossible; an rvalid with `outstanding`=0 is a protocol error and is ignored.
- Consume: the head is popped when `inst_valid && !id_stall`.
- Simultaneous push and pop: both happen; `count` is unchanged.
- Redirect takes priority over everything in the same cycle:
  - FIFO is flushed (`count` <- 0) and any pop is cancelled.
  - `fetch_pc` and `resp_pc` <- {redirect_pc[31:2], 2'b00}.
  - A response arriving that cycle is discarded.
  - `drop_cnt` <- `outstanding` − `imem_rvalid`.
  - No request is issued that cycle.
- Back-to-back redirects: each one recomputes `drop_cnt` the same way; the last redirect wins.
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `inst`=0, `inst_valid`=0, `inst_pc`=RESET_PC.
  - `fetch_pc`=`resp_pc`=RESET_PC.
  - `outstanding`, `drop_cnt` and `count` = 0.
- Reset mid-operation: all state returns to reset values. In-flight responses that arrive later are ignored because `outstanding`=0 (the memory side is reset together with this block).

## Timing
- First `imem_req`=1 in the first cycle after `rst` falls.
- Rvalid in cycle N → `inst_valid` in cycle N+1. This is the latency when the queue is empty; there is no bypass.
- With single-cycle grant and 1-cycle memory latency, steady-state throughput is 1 instruction/cycle.
- Redirect in cycle N: `inst_valid`=0 in N+1, and the new-target request is issued in N+1.
- `inst`, `inst_pc` and `inst_valid` are taken directly from the FIFO head registers, with no combinational path from `id_stall` or `imem_*`.
- `imem_req` depends combinationally on `redirect` only.

## Structure
- Shared package `if_pkg`:
  - `XLEN`=32.
  - `BUBBLE_INST`=32'h0000_0000.
  - `PC_STEP`=4.
  - Typedef `if_entry_t` {pc[31:0], inst[31:0]}.
- Sub-module `if_fifo`: synchronous DEPTH×64 FIFO with push, pop, flush, count and head outputs. Flush has priority over push and pop.
- Top level: PC registers, credit/drop counters, request logic.

## Test plan
- Reset release, memory with 1-cycle latency, no stall → requests at 0x0, 0x4, 0x8, …; `inst_valid` rises 2 cycles after the first request; `inst_pc` sequence 0x0, 0x4, 0x8 with matching words.
- `id_stall` held high for 6 cycles → the queue fills to 4, `imem_req` drops, and `inst`/`inst_pc` hold. On release, the 4 buffered words drain in order with no gap.
- Redirect to 0x100 with 2 requests outstanding (3-cycle latency) → the next 2 responses are dropped, the first valid output is at `inst_pc`=0x100, and no stale word appears.
- Redirect in the same cycle as an rvalid and a pop → that response is dropped, the FIFO is empty next cycle, and `inst`=0.
- `imem_gnt` held low for 5 cycles → `imem_req` and `imem_addr`=0x4 stay stable, and `fetch_pc` does not advance.
- Assert `rst` while 3 requests are outstanding → next cycle all outputs are at reset values; after release, fetch restarts at RESET_PC.
